dc_reset_sequencer: RTL and testbench
=====================================

// Module: dc_reset_sequencer
// PURPOSE
//  Sequences the Dreamcast reset line (DC_NRESET, open-drain) in the reset_clock domain.
//  Arbitrates two requesters: the ESP/I2C reset_dc flag (after Flag_CrossDomain) and a
//  controller button-combo hold from the maple decoder. Drives a timed low pulse, checks
//  that the pin returns high, then enforces a cooldown. Reports status back to the I2C debug path.
// PARAMETERS
//  ASSERT_CYCLES      16_000_000   DC_NRESET low time (200 ms @ 80 MHz)
//  COMBO_HOLD_CYCLES  160_000_000  continuous combo hold required to request a reset (2 s)
//  RELEASE_TIMEOUT    800_000      max cycles for the pin to read high after release (10 ms)
//  COOLDOWN_CYCLES    80_000_000   minimum idle time after a sequence completes (1 s)
//  CNT_W              32           width of the internal timers
// PORTS
//  reset_clock     in   1   clock, internal oscillator
//  reset           in   1   reset of the reset_clock domain: asynchronous, active-high
//  req_i2c         in   1   single-cycle reset request, already in reset_clock domain
//  combo_held      in   1   async level, 1 = reset button combo pressed; 2-FF synced inside
//  nreset_pin_in   in   1   async readback of DC_NRESET pad; 2-FF synced inside
//  nreset_drive    out  1   1 = pull DC_NRESET low (top level: pad = drive ? 0 : z)
//  busy            out  1   1 in any state except IDLE
//  last_source     out  2   00 none, 01 i2c, 10 combo, 11 external (pin pulled low by others)
//  reset_count     out  8   completed sequences, wraps 255 -> 0
//  release_error   out  1   sticky: pin failed to read high within RELEASE_TIMEOUT
// BEHAVIOUR
//  Reset values: nreset_drive=0, busy=0, last_source=00, reset_count=0, release_error=0,
//   state=IDLE, all timers=0, pending=0, combo_armed=1, sync FFs = 1 (pin), 0 (combo).
//  States: IDLE -> ASSERT -> RELEASE_WAIT -> COOLDOWN -> IDLE.
//  IDLE: req_i2c or pending -> ASSERT, last_source=01. Else combo_fire -> ASSERT,
//   last_source=10. i2c wins when both occur in the same cycle. Else synced pin low for
//   1024 consecutive cycles -> last_source=11, reset_count increments, stay IDLE (observe only).
//  Combo: hold counter counts while synced combo=1 and combo_armed; clears when combo=0.
//   combo_fire is one pulse when counter reaches COMBO_HOLD_CYCLES-1; then combo_armed=0
//   until combo releases (no auto-repeat while held).
//  ASSERT: nreset_drive=1 registered, asserted the cycle after the request is accepted;
//   timer counts ASSERT_CYCLES cycles, then -> RELEASE_WAIT with nreset_drive=0.
//  RELEASE_WAIT: wait for synced pin = 1 -> COOLDOWN, reset_count += 1. Timeout
//   RELEASE_TIMEOUT cycles -> release_error=1, -> COOLDOWN, count not incremented.
//  COOLDOWN: COOLDOWN_CYCLES cycles, then -> IDLE. req_i2c here sets pending (one deep,
//   extra requests merge); serviced on return to IDLE. Combo counter keeps running but
//   combo_fire in COOLDOWN is discarded (combo_armed still cleared).
//  req_i2c during ASSERT/RELEASE_WAIT: ignored, no pending.
//  release_error clears only on reset. Timers saturate-free: compared with ==, cleared on
//   every state entry. reset mid-sequence: nreset_drive drops asynchronously to 0.
//  Latency: req_i2c at cycle N -> nreset_drive=1 at N+1 -> 0 at N+1+ASSERT_CYCLES.
// TESTING  (bench overrides: ASSERT=16, COMBO_HOLD=32, RELEASE_TIMEOUT=8, COOLDOWN=20)
//  req_i2c pulse at cycle 10, pin model follows drive -> drive high cycles 11..26,
//   busy falls after cooldown, reset_count=1, last_source=01.
//  combo_held 1 for 40 cycles -> one sequence, last_source=10; keep held 200 cycles
//   -> no second sequence; release, hold 40 again -> second sequence, count=2.
//  req_i2c and combo_fire same cycle -> last_source=01, only one sequence.
//  pin model held low after release -> release_error=1 after 8 cycles, count unchanged,
//   COOLDOWN entered.
//  req_i2c x3 during COOLDOWN -> exactly one extra sequence after cooldown; req_i2c
//   during ASSERT -> none.
//  external pin low 1100 cycles while IDLE -> last_source=11, count+1, drive stays 0;
//   reset asserted mid-ASSERT -> nreset_drive=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/dc_reset_sequencer.sv
// Dreamcast reset-line sequencer: arbitrates I2C and button-combo requests, drives a timed
// low pulse on DC_NRESET, verifies release, then enforces a cooldown before the next sequence.
`timescale 1ns/1ps
module dc_reset_sequencer #(
  parameter int unsigned ASSERT_CYCLES     = 16_000_000,
  parameter int unsigned COMBO_HOLD_CYCLES = 160_000_000,
  parameter int unsigned RELEASE_TIMEOUT   = 800_000,
  parameter int unsigned COOLDOWN_CYCLES   = 80_000_000,
  parameter int unsigned CNT_W             = 32
) (
  input  logic       reset_clock,
  input  logic       reset,
  input  logic       req_i2c,
  input  logic       combo_held,
  input  logic       nreset_pin_in,
  output logic       nreset_drive,
  output logic       busy,
  output logic [1:0] last_source,
  output logic [7:0] reset_count,
  output logic       release_error
);

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(COMBO_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE_WAIT, S_COOLDOWN} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] hold_cnt;
  logic [9:0]       ext_cnt;
  logic             ext_done;
  logic             pending;
  logic             combo_armed;
  logic             pin_s1, pin_s2;
  logic             combo_s1, combo_s2;
  logic             combo_fire;

  assign combo_fire = combo_s2 && combo_armed && (hold_cnt == HOLD_LAST);

  always_ff @(posedge reset_clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      hold_cnt      <= '0;
      ext_cnt       <= '0;
      ext_done      <= 1'b0;
      pending       <= 1'b0;
      combo_armed   <= 1'b1;
      pin_s1        <= 1'b1;
      pin_s2        <= 1'b1;
      combo_s1      <= 1'b0;
      combo_s2      <= 1'b0;
      nreset_drive  <= 1'b0;
      busy          <= 1'b0;
      last_source   <= 2'b00;
      reset_count   <= 8'd0;
      release_error <= 1'b0;
    end else begin
      pin_s1   <= nreset_pin_in;
      pin_s2   <= pin_s1;
      combo_s1 <= combo_held;
      combo_s2 <= combo_s1;

      // One fire per press: disarmed after firing until the combo is released.
      if (!combo_s2) begin
        hold_cnt    <= '0;
        combo_armed <= 1'b1;
      end else if (combo_fire) begin
        hold_cnt    <= '0;
        combo_armed <= 1'b0;
      end else if (combo_armed) begin
        hold_cnt    <= hold_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (req_i2c || pending) begin
            state        <= S_ASSERT;
            nreset_drive <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            pending      <= 1'b0;
            last_source  <= 2'b01;
            ext_cnt      <= '0;
            ext_done     <= 1'b0;
          end else if (combo_fire) begin
            state        <= S_ASSERT;
            nreset_drive <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            last_source  <= 2'b10;
            ext_cnt      <= '0;
            ext_done     <= 1'b0;
          end else if (pin_s2) begin
            ext_cnt  <= '0;
            ext_done <= 1'b0;
          end else if (!ext_done) begin
            // Someone else is holding the console in reset; record it once per episode.
            if (ext_cnt == 10'd1023) begin
              ext_done    <= 1'b1;
              last_source <= 2'b11;
              reset_count <= reset_count + 1'b1;
            end else begin
              ext_cnt <= ext_cnt + 1'b1;
            end
          end
        end
        S_ASSERT: begin
          if (timer == ASSERT_LAST) begin
            state        <= S_RELEASE_WAIT;
            nreset_drive <= 1'b0;
            timer        <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RELEASE_WAIT: begin
          if (pin_s2) begin
            state       <= S_COOLDOWN;
            reset_count <= reset_count + 1'b1;
            timer       <= '0;
          end else if (timer == RELEASE_LAST) begin
            state         <= S_COOLDOWN;
            release_error <= 1'b1;
            timer         <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (req_i2c) pending <= 1'b1;
          if (timer == COOL_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_reset_sequencer.sv
// Directed bench for dc_reset_sequencer: expected sequence outcomes are queued when a
// request is driven and checked when the sequencer returns to idle.
`timescale 1ns/1ps
module tb_dc_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       combo = 1'b0;
  logic       pin;
  logic       drive, busy, err;
  logic [1:0] src;
  logic [7:0] cnt;
  logic       ext_low = 1'b0;
  logic       stuck_low = 1'b0;

  always #5 clk = ~clk;

  // Open-drain pad: low when we drive it or when something else pulls it.
  assign pin = ~(drive | ext_low | stuck_low);

  dc_reset_sequencer #(
    .ASSERT_CYCLES(16), .COMBO_HOLD_CYCLES(32), .RELEASE_TIMEOUT(8),
    .COOLDOWN_CYCLES(20), .CNT_W(32)
  ) dut (
    .reset_clock(clk), .reset(rst), .req_i2c(req), .combo_held(combo),
    .nreset_pin_in(pin), .nreset_drive(drive), .busy(busy),
    .last_source(src), .reset_count(cnt), .release_error(err)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0, cur_w = 0, last_w = 0;
  logic prev_drive = 1'b0;

  always @(posedge clk) begin
    prev_drive <= drive;
    if (drive && !prev_drive) pulses <= pulses + 1;
    if (drive) cur_w <= cur_w + 1;
    else if (cur_w != 0) begin
      last_w <= cur_w;
      cur_w  <= 0;
    end
  end

  typedef struct {
    string      tag;
    logic [1:0] src;
    logic [7:0] cnt;
    logic       err;
    int         pulses;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic push_exp(input string t, input logic [1:0] s, input logic [7:0] c,
                          input logic e, input int p);
    exp_t x;
    x.tag = t; x.src = s; x.cnt = c; x.err = e; x.pulses = p;
    sb.push_back(x);
  endtask

  task automatic wait_busy(input string tag, input logic v, input int bound);
    int n = 0;
    while (busy !== v && n < bound) begin
      tick();
      n++;
    end
    if (busy !== v) check(tag, busy, v);
  endtask

  task automatic wait_drive(input string tag, input logic v, input int bound);
    int n = 0;
    while (drive !== v && n < bound) begin
      tick();
      n++;
    end
    if (drive !== v) check(tag, drive, v);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_src"}, src, e.src);
    check({e.tag, "_cnt"}, cnt, e.cnt);
    check({e.tag, "_err"}, err, e.err);
    check({e.tag, "_pulses"}, pulses, e.pulses);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_drive", drive, 0);
    check("rst_busy", busy, 0);
    check("rst_src", src, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Plain I2C request with exact pulse timing.
    repeat (9) tick();
    push_exp("i2c", 2'b01, 8'd1, 1'b0, 1);
    pulse_req();
    check("i2c_drive_first", drive, 1);
    repeat (15) tick();
    check("i2c_drive_last", drive, 1);
    tick();
    check("i2c_drive_off", drive, 0);
    check("i2c_busy_after_drive", busy, 1);
    wait_busy("i2c_idle_timeout", 1'b0, 100);
    pop_cmp();
    check("i2c_width", last_w, 16);

    // Combo hold, no auto-repeat while held, re-arm after release.
    push_exp("combo1", 2'b10, 8'd2, 1'b0, 2);
    combo = 1'b1;
    wait_busy("combo1_start_timeout", 1'b1, 60);
    wait_busy("combo1_idle_timeout", 1'b0, 100);
    pop_cmp();
    repeat (200) tick();
    check("combo_no_repeat", pulses, 2);
    check("combo_no_repeat_busy", busy, 0);
    combo = 1'b0;
    repeat (5) tick();
    push_exp("combo2", 2'b10, 8'd3, 1'b0, 3);
    combo = 1'b1;
    wait_busy("combo2_start_timeout", 1'b1, 60);
    wait_busy("combo2_idle_timeout", 1'b0, 100);
    pop_cmp();
    combo = 1'b0;
    repeat (5) tick();

    // I2C request lands on the same edge as combo_fire.
    push_exp("tie", 2'b01, 8'd4, 1'b0, 4);
    combo = 1'b1;
    repeat (33) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("tie_busy", busy, 1);
    wait_busy("tie_idle_timeout", 1'b0, 100);
    pop_cmp();
    repeat (50) tick();
    check("tie_single", pulses, 4);
    combo = 1'b0;
    repeat (5) tick();

    // Pin stuck low after release: timeout, error, no count.
    stuck_low = 1'b1;
    push_exp("stuck", 2'b01, 8'd4, 1'b1, 5);
    pulse_req();
    wait_drive("stuck_drive_timeout", 1'b0, 40);
    check("stuck_err_early", err, 0);
    repeat (7) tick();
    check("stuck_err_at7", err, 0);
    tick();
    check("stuck_err_at8", err, 1);
    check("stuck_cooldown_busy", busy, 1);
    stuck_low = 1'b0;
    wait_busy("stuck_idle_timeout", 1'b0, 60);
    pop_cmp();

    // Requests during ASSERT are dropped; three during COOLDOWN merge into one.
    push_exp("cd_a", 2'b01, 8'd5, 1'b1, 6);
    pulse_req();
    repeat (3) tick();
    pulse_req();
    wait_drive("cd_drive_timeout", 1'b0, 40);
    repeat (8) tick();
    pulse_req();
    tick();
    pulse_req();
    tick();
    pulse_req();
    push_exp("cd_b", 2'b01, 8'd6, 1'b1, 7);
    wait_busy("cd_a_idle_timeout", 1'b0, 60);
    pop_cmp();
    wait_busy("cd_b_start_timeout", 1'b1, 5);
    wait_busy("cd_b_idle_timeout", 1'b0, 100);
    pop_cmp();
    repeat (60) tick();
    check("cd_no_extra", pulses, 7);

    // External reset observed while idle.
    push_exp("ext", 2'b11, 8'd7, 1'b1, 7);
    ext_low = 1'b1;
    repeat (1020) tick();
    check("ext_early_cnt", cnt, 6);
    repeat (80) tick();
    check("ext_drive", drive, 0);
    check("ext_busy", busy, 0);
    ext_low = 1'b0;
    tick();
    pop_cmp();

    // Reset mid-ASSERT drops the drive immediately.
    pulse_req();
    repeat (4) tick();
    check("pre_rst_drive", drive, 1);
    check("pre_rst_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    check("midrst_drive", drive, 0);
    check("midrst_busy", busy, 0);
    check("midrst_src", src, 0);
    check("midrst_cnt", cnt, 0);
    check("midrst_err", err, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
